// File: rtl/seven_seg_pkg.sv
// Shared display constants: segment patterns for BCD 0..9, the invalid-digit
// code, and the scan-capture state encoding.
package seven_seg_pkg;

  localparam logic [7:0] SEG_0 = 8'hEB;
  localparam logic [7:0] SEG_1 = 8'h28;
  localparam logic [7:0] SEG_2 = 8'hB3;
  localparam logic [7:0] SEG_3 = 8'hBA;
  localparam logic [7:0] SEG_4 = 8'h78;
  localparam logic [7:0] SEG_5 = 8'hDA;
  localparam logic [7:0] SEG_6 = 8'hDB;
  localparam logic [7:0] SEG_7 = 8'hA8;
  localparam logic [7:0] SEG_8 = 8'hFB;
  localparam logic [7:0] SEG_9 = 8'hFA;

  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_e;

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational inverse of the BCD-to-segment encoder: returns {illegal, bcd}.
module seg_to_bcd
  import seven_seg_pkg::*;
(
  input  logic [7:0] i_seg,
  output logic [4:0] o_code
);

  // Table lookup; anything outside the ten legal glyphs (blank included) is invalid
  always_comb begin
    o_code = {1'b1, BCD_INVALID};
    case (i_seg)
      SEG_0:   o_code = {1'b0, 4'd0};
      SEG_1:   o_code = {1'b0, 4'd1};
      SEG_2:   o_code = {1'b0, 4'd2};
      SEG_3:   o_code = {1'b0, 4'd3};
      SEG_4:   o_code = {1'b0, 4'd4};
      SEG_5:   o_code = {1'b0, 4'd5};
      SEG_6:   o_code = {1'b0, 4'd6};
      SEG_7:   o_code = {1'b0, 4'd7};
      SEG_8:   o_code = {1'b0, 4'd8};
      SEG_9:   o_code = {1'b0, 4'd9};
      default: o_code = {1'b1, BCD_INVALID};
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Recovers BCD digits from a multiplexed seven-segment bus: synchronise, wait
// for each digit slot to settle, decode, and publish a frame once all are seen.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   invalid_out,
  output logic                    frame_valid,
  output logic                    sel_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [7:0]              r_seg_meta;
  logic [7:0]              r_seg_s;
  logic [NUM_DIGITS-1:0]   r_sel_meta;
  logic [NUM_DIGITS-1:0]   r_sel_s;
  logic [7:0]              r_prev_seg;
  logic [NUM_DIGITS-1:0]   r_prev_sel;
  logic [CNT_W-1:0]        r_cnt;
  state_e                  r_state;
  logic [4*NUM_DIGITS-1:0] r_shadow_bcd;
  logic [NUM_DIGITS-1:0]   r_shadow_inv;
  logic [NUM_DIGITS-1:0]   r_mask;

  logic                    w_changed;
  logic                    w_new_onehot;
  logic                    w_prev_multi;
  logic                    w_capture;
  logic [NUM_DIGITS-1:0]   w_cap_mask;
  logic [4:0]              w_code;

  // The stable pair lives in r_prev_*, so that is what gets decoded on capture
  seg_to_bcd u_seg_to_bcd (
    .i_seg  (r_prev_seg),
    .o_code (w_code)
  );

  // Two-flop synchronisers for the asynchronous display pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_meta <= 8'h00;
      r_seg_s    <= 8'h00;
      r_sel_meta <= '0;
      r_sel_s    <= '0;
    end else begin
      r_seg_meta <= seg_in;
      r_seg_s    <= r_seg_meta;
      r_sel_meta <= dig_sel;
      r_sel_s    <= r_sel_meta;
    end
  end

  // Capture fires off the registered count, so the sample arriving on the
  // capture edge may already differ without cancelling the settled digit.
  always_comb begin
    w_changed    = (r_seg_s != r_prev_seg) || (r_sel_s != r_prev_sel);
    w_new_onehot = $onehot(r_sel_s);
    w_prev_multi = (r_prev_sel != '0) && !$onehot(r_prev_sel);
    w_capture    = (r_state == SETTLE) && (r_cnt == CNT_MAX);
    w_cap_mask   = w_capture ? r_prev_sel : '0;
  end

  // Dwell tracking: previous pair, stability count, slot state, select error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_seg <= 8'h00;
      r_prev_sel <= '0;
      r_cnt      <= '0;
      r_state    <= WAIT;
      sel_err    <= 1'b0;
    end else begin
      r_prev_seg <= r_seg_s;
      r_prev_sel <= r_sel_s;

      if (w_changed) begin
        r_cnt <= CNT_ONE;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_ONE;
      end

      if ((r_state == WAIT) && w_prev_multi && (r_cnt == CNT_MAX)) begin
        sel_err <= 1'b1;
      end

      case (r_state)
        WAIT: begin
          if (w_changed && w_new_onehot) begin
            r_state <= SETTLE;
          end
        end
        SETTLE: begin
          if (w_changed) begin
            r_state <= w_new_onehot ? SETTLE : WAIT;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= HELD;
          end
        end
        HELD: begin
          if (w_changed) begin
            r_state <= w_new_onehot ? SETTLE : WAIT;
          end
        end
        default: r_state <= WAIT;
      endcase
    end
  end

  // Shadow capture and frame publication; a capture on the publish edge seeds the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_bcd <= '0;
      r_shadow_inv <= '0;
      r_mask       <= '0;
      bcd_out      <= '0;
      invalid_out  <= '0;
      frame_valid  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_cap_mask[i]) begin
          r_shadow_bcd[4*i +: 4] <= w_code[3:0];
          r_shadow_inv[i]        <= w_code[4];
        end
      end

      if (&r_mask) begin
        bcd_out     <= r_shadow_bcd;
        invalid_out <= r_shadow_inv;
        frame_valid <= 1'b1;
        r_mask      <= w_cap_mask;
      end else begin
        frame_valid <= 1'b0;
        r_mask      <= r_mask | w_cap_mask;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Self-checking bench: directed scenarios plus random dwells, scored against a
// run-length model of the display bus.
module tb_seven_seg_scan_decoder;

  localparam int ND = 4;
  localparam int S  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    seg_in;
  logic [ND-1:0] dig_sel;
  logic [4*ND-1:0] bcd_out;
  logic [ND-1:0] invalid_out;
  logic          frame_valid;
  logic          sel_err;

  always #5 clk = ~clk;

  seven_seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .bcd_out     (bcd_out),
    .invalid_out (invalid_out),
    .frame_valid (frame_valid),
    .sel_err     (sel_err)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int fv_cnt = 0;
  int fv_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: each run of identical pin values lasting S samples yields one capture
  typedef struct packed {logic [4*ND-1:0] bcd; logic [ND-1:0] inv;} frame_t;
  frame_t        exp_q[$];
  frame_t        f_mon;
  logic [3:0]    m_bcd [ND];
  logic          m_inv [ND];
  logic [ND-1:0] m_mask;
  logic [ND-1:0] m_sel;
  logic [7:0]    m_seg;
  int            m_len;
  bit            m_done;
  bit            m_sel_err;
  int            m_frames = 0;
  int            run_start = 0;
  logic [7:0]    legal [10] = '{8'hEB, 8'h28, 8'hB3, 8'hBA, 8'h78,
                                8'hDA, 8'hDB, 8'hA8, 8'hFB, 8'hFA};

  function automatic logic [4:0] ref_decode(input logic [7:0] p);
    for (int k = 0; k < 10; k++) begin
      if (legal[k] == p) return {1'b0, 4'(k)};
    end
    return 5'h1F;
  endfunction

  function automatic void model_reset();
    m_mask = '0;
    for (int d = 0; d < ND; d++) begin
      m_bcd[d] = 4'h0;
      m_inv[d] = 1'b0;
    end
    m_sel = '0;
    m_seg = 8'h00;
    m_len = 0;
    m_done = 1'b1;
    m_sel_err = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_step(input logic [ND-1:0] sel, input logic [7:0] seg);
    logic [4:0] code;
    frame_t fr;
    int idx;
    if (sel != m_sel || seg != m_seg) begin
      m_sel = sel;
      m_seg = seg;
      m_len = 0;
      m_done = 1'b0;
      run_start = cyc;
    end
    m_len++;
    if (!m_done && m_len >= S) begin
      m_done = 1'b1;
      if ($countones(sel) == 1) begin
        idx = 0;
        for (int d = 0; d < ND; d++) if (sel[d]) idx = d;
        code = ref_decode(seg);
        m_bcd[idx] = code[3:0];
        m_inv[idx] = code[4];
        m_mask[idx] = 1'b1;
        if (&m_mask) begin
          for (int d = 0; d < ND; d++) begin
            fr.bcd[4*d +: 4] = m_bcd[d];
            fr.inv[d] = m_inv[d];
          end
          exp_q.push_back(fr);
          m_frames++;
          m_mask = '0;
        end
      end else if ($countones(sel) > 1) begin
        m_sel_err = 1'b1;
      end
    end
  endfunction

  task automatic apply(input logic [ND-1:0] sel, input logic [7:0] seg, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      dig_sel = sel;
      seg_in  = seg;
      model_step(sel, seg);
    end
  endtask

  task automatic flush();
    apply('0, 8'h00, S + 6);
  endtask

  // Frame scoreboard
  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt++;
      fv_cyc = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL frame_unexpected: got bcd=%h inv=%b, required no frame", bcd_out, invalid_out);
      end else begin
        f_mon = exp_q.pop_front();
        if ({bcd_out, invalid_out} !== f_mon) begin
          miscompares++;
          $display("FAIL frame_data: got bcd=%h inv=%b, required bcd=%h inv=%b",
                   bcd_out, invalid_out, f_mon.bcd, f_mon.inv);
        end
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors += 4;
    if (bcd_out !== 16'h0)     begin miscompares++; $display("FAIL reset_bcd: got %h, required 0000", bcd_out); end
    if (invalid_out !== 4'h0)  begin miscompares++; $display("FAIL reset_inv: got %b, required 0000", invalid_out); end
    if (frame_valid !== 1'b0)  begin miscompares++; $display("FAIL reset_fv: got %b, required 0", frame_valid); end
    if (sel_err !== 1'b0)      begin miscompares++; $display("FAIL reset_selerr: got %b, required 0", sel_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int f0;
    int t4;
    f0 = fv_cnt;
    apply(4'b0001, 8'hEB, 10);
    apply(4'b0010, 8'h28, 10);
    apply(4'b0100, 8'hB3, 10);
    apply(4'b1000, 8'hBA, 1);
    t4 = run_start;
    apply(4'b1000, 8'hBA, 9);
    flush();
    vectors += 5;
    if (fv_cnt - f0 !== 1)        begin miscompares++; $display("FAIL basic_count: got %0d, required 1", fv_cnt - f0); end
    if (fv_cyc - t4 !== S + 4)    begin miscompares++; $display("FAIL basic_latency: got %0d, required %0d", fv_cyc - t4, S + 4); end
    if (bcd_out !== 16'h3210)     begin miscompares++; $display("FAIL basic_bcd: got %h, required 3210", bcd_out); end
    if (invalid_out !== 4'b0000)  begin miscompares++; $display("FAIL basic_inv: got %b, required 0000", invalid_out); end
    if (sel_err !== 1'b0)         begin miscompares++; $display("FAIL basic_selerr: got %b, required 0", sel_err); end
  endtask

  task automatic test_glitch();
    int f0;
    f0 = fv_cnt;
    apply(4'b0010, 8'h78, 4);
    apply(4'b0010, 8'h00, 2);
    apply(4'b0010, 8'h78, 4);
    apply(4'b0001, 8'hDB, 10);
    apply(4'b0100, 8'hA8, 10);
    apply(4'b1000, 8'hFB, 10);
    flush();
    vectors += 3;
    if (fv_cnt - f0 !== 1)        begin miscompares++; $display("FAIL glitch_count: got %0d, required 1", fv_cnt - f0); end
    if (bcd_out !== 16'h8746)     begin miscompares++; $display("FAIL glitch_bcd: got %h, required 8746", bcd_out); end
    if (invalid_out !== 4'b0000)  begin miscompares++; $display("FAIL glitch_inv: got %b, required 0000", invalid_out); end
  endtask

  task automatic test_illegal();
    int f0;
    f0 = fv_cnt;
    apply(4'b0001, 8'hFA, 10);
    apply(4'b0010, 8'h28, 10);
    apply(4'b0100, 8'h55, 10);
    apply(4'b1000, 8'hEB, 10);
    flush();
    vectors += 3;
    if (fv_cnt - f0 !== 1)        begin miscompares++; $display("FAIL illegal_count: got %0d, required 1", fv_cnt - f0); end
    if (bcd_out !== 16'h0F19)     begin miscompares++; $display("FAIL illegal_bcd: got %h, required 0f19", bcd_out); end
    if (invalid_out !== 4'b0100)  begin miscompares++; $display("FAIL illegal_inv: got %b, required 0100", invalid_out); end
  endtask

  task automatic test_short_dwell();
    int f0;
    f0 = fv_cnt;
    apply(4'b0001, 8'hEB, S - 1);
    apply(4'b0010, 8'hB3, 10);
    apply(4'b0100, 8'hBA, 10);
    apply(4'b1000, 8'h78, 10);
    flush();
    vectors += 2;
    if (fv_cnt - f0 !== 0)        begin miscompares++; $display("FAIL short_count: got %0d, required 0", fv_cnt - f0); end
    if (bcd_out !== 16'h0F19)     begin miscompares++; $display("FAIL short_hold: got %h, required 0f19", bcd_out); end
  endtask

  task automatic test_multi_hot();
    int f0;
    f0 = fv_cnt;
    apply(4'b0011, 8'hEB, 10);
    flush();
    vectors += 2;
    if (sel_err !== 1'b1)         begin miscompares++; $display("FAIL multi_selerr: got %b, required 1", sel_err); end
    if (fv_cnt - f0 !== 0)        begin miscompares++; $display("FAIL multi_count: got %0d, required 0", fv_cnt - f0); end
    apply('0, 8'h00, 20);
    apply(4'b0001, 8'hDA, 10);
    flush();
    vectors += 4;
    if (sel_err !== 1'b1)         begin miscompares++; $display("FAIL multi_sticky: got %b, required 1", sel_err); end
    if (fv_cnt - f0 !== 1)        begin miscompares++; $display("FAIL multi_mask_count: got %0d, required 1", fv_cnt - f0); end
    if (bcd_out !== 16'h4325)     begin miscompares++; $display("FAIL multi_bcd: got %h, required 4325", bcd_out); end
    if (invalid_out !== 4'b0000)  begin miscompares++; $display("FAIL multi_inv: got %b, required 0000", invalid_out); end
  endtask

  task automatic test_reset_midframe();
    int f0;
    f0 = fv_cnt;
    apply(4'b0001, 8'hA8, 10);
    apply(4'b0010, 8'hFB, 10);
    apply(4'b0100, 8'hFA, 10);
    flush();
    vectors++;
    if (fv_cnt - f0 !== 0)        begin miscompares++; $display("FAIL mid_precount: got %0d, required 0", fv_cnt - f0); end
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    vectors += 4;
    if (bcd_out !== 16'h0)        begin miscompares++; $display("FAIL mid_rst_bcd: got %h, required 0000", bcd_out); end
    if (invalid_out !== 4'h0)     begin miscompares++; $display("FAIL mid_rst_inv: got %b, required 0000", invalid_out); end
    if (frame_valid !== 1'b0)     begin miscompares++; $display("FAIL mid_rst_fv: got %b, required 0", frame_valid); end
    if (sel_err !== 1'b0)         begin miscompares++; $display("FAIL mid_rst_selerr: got %b, required 0", sel_err); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    f0 = fv_cnt;
    apply(4'b0001, 8'h28, 10);
    apply(4'b0010, 8'hB3, 10);
    apply(4'b0100, 8'hBA, 10);
    apply(4'b1000, 8'h78, 10);
    flush();
    vectors += 3;
    if (fv_cnt - f0 !== 1)        begin miscompares++; $display("FAIL mid_count: got %0d, required 1", fv_cnt - f0); end
    if (bcd_out !== 16'h4321)     begin miscompares++; $display("FAIL mid_bcd: got %h, required 4321", bcd_out); end
    if (invalid_out !== 4'b0000)  begin miscompares++; $display("FAIL mid_inv: got %b, required 0000", invalid_out); end
  endtask

  task automatic test_random();
    logic [ND-1:0] sel;
    logic [7:0]    seg;
    int            r;
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      sel = ND'(1) << $urandom_range(0, ND - 1);
      else if (r < 9) sel = '0;
      else            sel = 4'b0101 << $urandom_range(0, 1);
      if ($urandom_range(0, 4) == 0) seg = 8'($urandom);
      else                           seg = legal[$urandom_range(0, 9)];
      apply(sel, seg, $urandom_range(1, 8));
    end
    flush();
    vectors += 3;
    if (fv_cnt !== m_frames)      begin miscompares++; $display("FAIL rand_count: got %0d, required %0d", fv_cnt, m_frames); end
    if (exp_q.size() !== 0)       begin miscompares++; $display("FAIL rand_pending: got %0d frames missing, required 0", exp_q.size()); end
    if (sel_err !== m_sel_err)    begin miscompares++; $display("FAIL rand_selerr: got %b, required %b", sel_err, m_sel_err); end
  endtask

  initial begin
    rst_n   = 1'b0;
    dig_sel = '0;
    seg_in  = 8'h00;
    model_reset();
    test_reset();
    test_basic();
    test_glitch();
    test_illegal();
    test_short_dwell();
    test_multi_hot();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
